// File: rtl/mod_counter_chain.sv
// rtl/mod_counter_chain.sv - cascaded programmable-modulus BCD counter chain
//
// Ports:
//   clk       rising-edge clock
//   rset      synchronous active-low reset
//   en        count enable, one step per clk while high
//   up        direction: 1 = increment, 0 = decrement
//   load      synchronous parallel load of load_val
//   load_val  load value, digit i in [4i+3:4i]
//   mode      modulus of digit i in [4i+3:4i] (<2 acts as 1, >10 acts as 10)
//   count     current count, digit i in [4i+3:4i]
//   digit_tc  combinational terminal-count flag per digit
//   ov        registered chain-wrap flag
//
// Optional feature: define MOD_CHAIN_SAT_EN to saturate at all-max / all-zero
// instead of wrapping; ov then becomes sticky until load or reset.

module mod_counter_chain #(
   parameter int DIGITS = 6,
   parameter int DW     = 4
) (
   input  logic                 clk,
   input  logic                 rset,
   input  logic                 en,
   input  logic                 up,
   input  logic                 load,
   input  logic [DIGITS*DW-1:0] load_val,
   input  logic [DIGITS*DW-1:0] mode,
   output logic [DIGITS*DW-1:0] count,
   output logic [DIGITS-1:0]    digit_tc,
   output logic                 ov
);

   localparam logic [DW-1:0] ONE = DW'(1);
   localparam logic [DW-1:0] TWO = DW'(2);
   localparam logic [DW-1:0] TEN = DW'(10);

   logic [DIGITS*DW-1:0] count_q;
   logic                 ov_q;

   logic [DIGITS*DW-1:0] step_val;
   logic [DIGITS*DW-1:0] load_fix;
   logic [DIGITS-1:0]    tc;
   // carry[i] is the carry into digit i; carry[DIGITS] is the whole-chain wrap
   logic [DIGITS:0]      carry;
   logic                 wrap;

   logic [DW-1:0] d;
   logic [DW-1:0] md;
   logic [DW-1:0] m;
   logic [DW-1:0] mx;
   logic [DW-1:0] nd;
   logic [DW-1:0] lv;

   always_comb begin
      step_val = '0;
      load_fix = '0;
      tc       = '0;
      carry    = '0;
      d        = '0;
      md       = '0;
      m        = ONE;
      mx       = '0;
      nd       = '0;
      lv       = '0;
      carry[0] = en;
      for (int i = 0; i < DIGITS; i++) begin
         d  = count_q[i*DW +: DW];
         md = mode[i*DW +: DW];
         lv = load_val[i*DW +: DW];

         if (md < TWO) begin
            m = ONE;
         end else if (md > TEN) begin
            m = TEN;
         end else begin
            m = md;
         end
         mx = m - ONE;

         // Out-of-range values count as terminal when going up so they wrap to 0
         tc[i]        = up ? (d >= mx) : (d == '0);
         carry[i + 1] = carry[i] & tc[i];

         if (!carry[i]) begin
            nd = d;
         end else if (up) begin
            nd = (d >= mx) ? '0 : d + ONE;
         end else begin
            // Out-of-range values going down resolve to the digit maximum
            nd = ((d == '0) || (d >= m)) ? mx : d - ONE;
         end

         step_val[i*DW +: DW] = nd;
         load_fix[i*DW +: DW] = (lv >= m) ? '0 : lv;
      end
      wrap = carry[DIGITS];
   end

   always_ff @(posedge clk) begin
      if (!rset) begin
         count_q <= '0;
         ov_q    <= 1'b0;
      end else if (load) begin
         count_q <= load_fix;
         ov_q    <= 1'b0;
`ifdef MOD_CHAIN_SAT_EN
      end else if (en) begin
         // A wrapping step becomes a hold; ov stays set until load or reset
         if (wrap) begin
            ov_q <= 1'b1;
         end else begin
            count_q <= step_val;
         end
      end
`else
      end else begin
         ov_q <= wrap;
         if (en) begin
            count_q <= step_val;
         end
      end
`endif
   end

   assign count    = count_q;
   assign digit_tc = tc;
   assign ov       = ov_q;

endmodule
